// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// LoadStoreUnit: single-outstanding RISC-V style load/store unit in front of a
// word-addressed data memory with asynchronous read and synchronous write.
//
// Loads and word stores take one memory cycle. Byte and half stores take two
// cycles: read the old word, then write it back merged with the new lane.
// Illegal funct3 codes go straight to the response with rsp_err set.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses are rejected (rsp_err=1, no write)
//   undefined -> misaligned half/word accesses are aligned down, rsp_err=0
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_write, req_funct3    store flag and RISC-V size/sign code
//   req_addr, req_wdata      byte address and store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_err       formatted load data, rejection flag
//   mem_addr, mem_we         memory word index and write enable
//   mem_wdata, mem_rdata     memory write word and async read word
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [WIDTH-1:0]      req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t                state;
   state_t                state_next;
   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [WIDTH-1:0]      old_q;
   logic [WIDTH-1:0]      rdata_q;
   logic                  err_q;

   logic                  req_legal;
   logic                  req_misaligned;
   logic [ADDR_WIDTH+1:0] req_addr_eff;
   logic [7:0]            lane_byte;
   logic [15:0]           lane_half;
   logic [WIDTH-1:0]      load_data;
   logic [WIDTH-1:0]      merged;

   // Address bits above the word index never reach the memory; the index
   // simply wraps around the memory size.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[WIDTH-1:ADDR_WIDTH+2];

   // Decode the incoming request: legality of the funct3 code for the access
   // direction, and misalignment relative to the access size (funct3[1:0]).
   always_comb begin
      req_legal = 1'b0;
      if (req_write) begin
         req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010);
      end else begin
         req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                     (req_funct3 == 3'b101);
      end
      req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      req_addr_eff = req_addr[ADDR_WIDTH+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_misaligned) begin
         req_legal = 1'b0;
      end
`else
      if (req_misaligned) begin
         req_addr_eff[1:0] = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
      end
`endif
   end

   // Lane extraction and sign/zero extension of the word read from memory,
   // plus the read-modify-write merge used by byte and half stores.
   always_comb begin
      lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_data = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
         3'b001:  load_data = {{(WIDTH-16){lane_half[15]}}, lane_half};
         3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane_byte};
         3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane_half};
         default: load_data = mem_rdata;
      endcase
      merged = old_q;
      if (funct3_q == 3'b000) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and memory-side outputs. mem_we is decoded from the state so
   // that reset drops it immediately and an interrupted store never lands.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = req_legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (write_q && (funct3_q == 3'b010)) begin
               mem_we     = 1'b1;
               mem_wdata  = wdata_q;
               state_next = RESP;
            end else if (write_q) begin
               state_next = WRITE;
            end else begin
               state_next = RESP;
            end
         end
         WRITE: begin
            mem_we     = 1'b1;
            mem_wdata  = merged;
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture and response data. The response registers are cleared
   // at accept so stores and rejected requests report zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         old_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q  <= req_write;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr_eff;
                  wdata_q  <= req_wdata;
                  rdata_q  <= '0;
                  err_q    <= !req_legal;
               end
            end
            ACCESS: begin
               if (write_q) begin
                  old_q <= mem_rdata;
               end else begin
                  rdata_q <= load_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_addr  = addr_q[ADDR_WIDTH+1:2];

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, data-memory word-index width (32 words).
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have: req_valid  in  1  request present; req_ready  out  1  unit can accept a request.
REQ-005 SHALL have: req_write  in  1  1=store, 0=load; req_funct3  in  3  RISC-V access size/sign code.
REQ-006 SHALL have: req_addr  in  WIDTH  byte address (ALU result); req_wdata  in  WIDTH  store data.
REQ-007 SHALL have: rsp_valid  out  1  response present; rsp_ready  in  1  consumer takes response.
REQ-008 SHALL have: rsp_rdata  out  WIDTH  formatted load data; rsp_err  out  1  request rejected.
REQ-009 SHALL have: mem_addr  out  ADDR_WIDTH  word index; mem_we  out  1  memory write enable; mem_wdata  out  WIDTH  word to write; mem_rdata  in  WIDTH  asynchronous read data of mem_addr.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-011 SHALL accept a request on a rising edge with req_valid=1 in IDLE, registering write, funct3, addr, wdata.
REQ-012 SHALL drive mem_addr = registered addr[ADDR_WIDTH+1:2]; higher address bits ignored (index wraps modulo 2^ADDR_WIDTH).
REQ-013 SHALL decode loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-014 Load: IDLE -> ACCESS (capture lane-selected, sign/zero-extended mem_rdata) -> RESP; rsp_valid two cycles after accept edge.
REQ-015 SW: IDLE -> ACCESS with mem_we=1, mem_wdata=wdata -> RESP; rsp_valid two cycles after accept edge.
REQ-016 SB/SH: IDLE -> ACCESS (read and register old word, mem_we=0) -> WRITE (mem_we=1, old word with addressed byte/half replaced by wdata[7:0]/[15:0]) -> RESP; rsp_valid three cycles after accept.
REQ-017 Byte lane = addr[1:0]; half lane = addr[1]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
REQ-018 Illegal funct3: IDLE -> RESP directly, rsp_err=1, rsp_rdata=0, no mem_we pulse; rsp_valid one cycle after accept.
REQ-019 mem_we SHALL be 1 for exactly one cycle per successful store and 0 in all other states.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready=1; then IDLE on next edge.
REQ-021 For stores rsp_rdata SHALL be 0; rsp_err SHALL be 0 for every legal access.
REQ-022 A new request SHALL be accepted no earlier than the cycle after RESP handshake completes (no overlap).
REQ-023 req_valid asserted outside IDLE SHALL be ignored (not registered).

Reset
REQ-024 rst=1 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-operation SHALL discard the in-flight request; a store in WRITE SHALL not complete.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-027 Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL behave as illegal (REQ-018 path, rsp_err=1, no write).
REQ-028 Undefined: low address bits below access size SHALL be forced to 0 (access aligned down), rsp_err=0.

Verification
REQ-029 SW addr 0x0000_0008 data 0xDEADBEEF, then LW 0x8 -> one mem_we pulse at word 2, rsp_rdata=0xDEADBEEF two cycles after accept.
REQ-030 Word 2=0xDEADBEEF; SB addr 0x9 data 0x55 -> read cycle then write 0xDEAD55EF, rsp_valid three cycles after accept; LB 0x9 -> 0x00000055; LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE.
REQ-031 SH addr 0xE data 0x8001 on word 3=0 -> word 3=0x80010000; LH 0xE -> 0xFFFF8001; LHU 0xE -> 0x00008001.
REQ-032 Load with funct3=011 -> rsp_err=1, rsp_rdata=0, rsp_valid one cycle after accept, mem_we never 1.
REQ-033 LW with rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, req_ready=0 throughout; release -> IDLE next edge; addr 0x84 hits word 1 (wrap).
REQ-034 Assert rst during WRITE of SB -> mem_we falls immediately, memory word unchanged, req_ready=1; LW addr 0x2 -> rsp_err=1 with LSU_MISALIGN_TRAP_EN, word 0 data without.
